// File: rtl/mux_uart_reporter.sv
// ---------------------------------------------------------------------------
// mux_uart_reporter
//
// Purpose: on request, snapshots the muxed value and streams it to a UART
// transmitter as a fixed-width ASCII decimal frame "ddd\r\n" (leading zeros
// kept). Bytes are paced with the tx_start / tx_busy handshake of uart_tx.
//
// Optional feature: define MODE_TAG_EN to prefix the frame with a source tag
// byte ('A', 'B' or 'C') decoded from the latched sw_mode. The frame is then
// "Tddd\r\n". With MODE_TAG_EN undefined, sw_mode is unused.
//
// Ports:
//   clk       in   1           system clock, rising edge
//   rst_n     in   1           asynchronous reset, active-low
//   sw_mode   in   4           mode switches (mux select encoding)
//   data      in   DATA_WIDTH  muxed value, legal 0..511
//   send_req  in   1           1-cycle request to transmit current value
//   tx_busy   in   1           uart_tx busy flag
//   tx_start  out  1           1-cycle pulse, tx_data valid same cycle
//   tx_data   out  8           byte to transmit (holds last byte sent)
//   busy      out  1           high while a frame is in progress
//   done      out  1           1-cycle pulse when the frame is complete
// ---------------------------------------------------------------------------
module mux_uart_reporter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            sw_mode,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  send_req,
   input  logic                  tx_busy,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   output logic                  busy,
   output logic                  done
);

`ifdef MODE_TAG_EN
   localparam int NUM_BYTES = 6;
`else
   localparam int NUM_BYTES = 5;
`endif
   localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_FINISH
   } state_t;

   state_t      state_q, state_d;
   logic        pending_q, pending_d;
   logic [2:0]  idx_q, idx_d;
   logic        tx_start_q, tx_start_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [7:0]  byte_q [NUM_BYTES];
   logic [7:0]  byte_d [NUM_BYTES];

   logic [9:0]  val_w, d2_w, d1_w, d0_w;

   function automatic logic [7:0] ascii_digit(input logic [9:0] d);
      return 8'(10'h030 + d);
   endfunction

`ifdef MODE_TAG_EN
   // Same source decode as the upstream mux; unknown modes fall back to 'A'.
   function automatic logic [7:0] tag_byte(input logic [3:0] sw);
      logic [7:0] t;
      case (sw)
         4'b0000, 4'b0001, 4'b0010, 4'b0011: t = 8'h41;
         4'b0100, 4'b0101:                   t = 8'h42;
         4'b1000, 4'b1001:                   t = 8'h43;
         default:                            t = 8'h41;
      endcase
      return t;
   endfunction
`else
   logic unused_sw_mode;
   assign unused_sw_mode = ^sw_mode;
`endif

   // Decimal split of the live input; only captured while in LOAD.
   assign val_w = 10'(data);
   assign d2_w  = val_w / 10'd100;
   assign d1_w  = (val_w / 10'd10) % 10'd10;
   assign d0_w  = val_w % 10'd10;

   // State register and control flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pending_q  <= 1'b0;
         idx_q      <= 3'd0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         idx_q      <= idx_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Frame byte store: pure data, only meaningful after LOAD
   always_ff @(posedge clk) begin
      byte_q <= byte_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (send_req || pending_q) state_d = S_LOAD;
         S_LOAD:      state_d = S_SEND;
         S_SEND:      state_d = S_WAIT_ACK;
         S_WAIT_ACK:  if (tx_busy) state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (!tx_busy) state_d = (idx_q == LAST_IDX) ? S_FINISH : S_SEND;
         S_FINISH:    state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Datapath / bookkeeping
   always_comb begin
      pending_d  = pending_q;
      idx_d      = idx_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      byte_d     = byte_q;

      // Requests arriving while a frame runs (including FINISH) coalesce.
      if (state_q == S_IDLE && state_d == S_LOAD)
         pending_d = 1'b0;
      else if (send_req && state_q != S_IDLE)
         pending_d = 1'b1;

      case (state_q)
         S_LOAD: begin
            idx_d = 3'd0;
`ifdef MODE_TAG_EN
            byte_d[0] = tag_byte(sw_mode);
            byte_d[1] = ascii_digit(d2_w);
            byte_d[2] = ascii_digit(d1_w);
            byte_d[3] = ascii_digit(d0_w);
            byte_d[4] = 8'h0D;
            byte_d[5] = 8'h0A;
`else
            byte_d[0] = ascii_digit(d2_w);
            byte_d[1] = ascii_digit(d1_w);
            byte_d[2] = ascii_digit(d0_w);
            byte_d[3] = 8'h0D;
            byte_d[4] = 8'h0A;
`endif
         end
         S_SEND: begin
            // Registered so the strobe and byte appear together one cycle later.
            tx_start_d = 1'b1;
            tx_data_d  = byte_q[idx_q];
         end
         S_WAIT_DONE: begin
            if (!tx_busy) idx_d = idx_q + 3'd1;
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      tx_start = tx_start_q;
      tx_data  = tx_data_q;
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_FINISH);
   end

endmodule

// File: tb/tb_mux_uart_reporter.sv
module tb_mux_uart_reporter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] sw_mode = 4'b0000;
   logic [7:0] data = 8'd0;
   logic       send_req = 1'b0;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int busy_cnt = 0;
   logic prev_start = 1'b0;
   logic [7:0] exp_q [$];

   mux_uart_reporter #(.DATA_WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_mode  (sw_mode),
      .data     (data),
      .send_req (send_req),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // uart_tx model: busy from the cycle after tx_start, for 10 cycles
   always @(posedge clk) begin
      if (tx_start) busy_cnt <= 10;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] tag_of(input logic [3:0] sw);
      case (sw)
         4'b0000, 4'b0001, 4'b0010, 4'b0011: return 8'h41;
         4'b0100, 4'b0101:                   return 8'h42;
         4'b1000, 4'b1001:                   return 8'h43;
         default:                            return 8'h41;
      endcase
   endfunction

   // Pushes the first n bytes of the expected frame for value v.
   task automatic push_frame(input int v, input int n);
      logic [7:0] f [$];
`ifdef MODE_TAG_EN
      f.push_back(tag_of(sw_mode));
`endif
      f.push_back(8'h30 + 8'(v / 100));
      f.push_back(8'h30 + 8'((v / 10) % 10));
      f.push_back(8'h30 + 8'(v % 10));
      f.push_back(8'h0D);
      f.push_back(8'h0A);
      for (int i = 0; i < n && i < f.size(); i++) exp_q.push_back(f[i]);
   endtask

   // Byte monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) done_cnt++;
         if (tx_start) begin
            check("start_width", int'(prev_start), 0);
            check("busy_at_start", int'(tx_busy), 0);
            if (exp_q.size() == 0) check("unexpected_byte", int'(tx_data), -1);
            else check("byte", int'(tx_data), int'(exp_q.pop_front()));
         end
         prev_start <= tx_start;
      end else begin
         prev_start <= 1'b0;
      end
   end

   task automatic pulse_req();
      @(negedge clk);
      send_req = 1'b1;
      @(negedge clk);
      send_req = 1'b0;
   endtask

   // Issues a request and returns at the negedge showing the first tx_start.
   task automatic request_frame(input int v, input int n);
      int lat;
      data = 8'(v);
      push_frame(v, n);
      pulse_req();
      check("busy_rise", int'(busy), 1);
      lat = 1;
      while (!tx_start && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 3);
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", int'(done), 1);
   endtask

   task automatic finish_frame();
      wait_done();
      @(negedge clk);
      check("busy_after", int'(busy), 0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_tx_start", int'(tx_start), 0);
      check("rst_tx_data", int'(tx_data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // basic frame
      request_frame(173, 6);
      finish_frame();
      check("done_count1", done_cnt, 1);
      check("tx_data_hold", int'(tx_data), 8'h0A);

      // leading zeros, max value
      request_frame(7, 6);
      finish_frame();
      request_frame(255, 6);
      finish_frame();
      check("done_count2", done_cnt, 3);

      // source tags
      sw_mode = 4'b0101;
      request_frame(42, 6);
      finish_frame();
      sw_mode = 4'b1111;
      request_frame(42, 6);
      finish_frame();
      sw_mode = 4'b1000;
      request_frame(42, 6);
      finish_frame();
      sw_mode = 4'b0000;
      check("done_count3", done_cnt, 6);

      // coalesced requests with data change mid-frame
      request_frame(100, 6);
      data = 8'd9;
      push_frame(9, 6);
      pulse_req();
      repeat (5) @(negedge clk);
      pulse_req();
      repeat (12) @(negedge clk);
      pulse_req();
      finish_frame();
      finish_frame();
      check("done_count4", done_cnt, 8);
      repeat (40) @(negedge clk);
      check("no_extra_frame", done_cnt, 8);

      // request in the FINISH cycle becomes pending
      request_frame(56, 6);
      wait_done();
      data = 8'd88;
      push_frame(88, 6);
      send_req = 1'b1;
      @(negedge clk);
      send_req = 1'b0;
      check("idle_after_finish", int'(busy), 0);
      finish_frame();
      check("done_count5", done_cnt, 10);
      check("queue_empty1", exp_q.size(), 0);

      // reset during byte 2
      request_frame(123, 2);
      n = 0;
      @(negedge clk);
      while (!tx_start && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("second_byte_seen", int'(tx_start), 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_tx_start", int'(tx_start), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_tx_data", int'(tx_data), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check("abort_done_count", done_cnt, 10);
      check("abort_busy_idle", int'(busy), 0);
      check("queue_empty2", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
